// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the arbiter, its two requesters (IF, LS) and the memory bus.
// The master modport is the arbiter's view; the slave modport is the surrounding environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic [STRB_W-1:0] ls_wstrb_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;

  logic              bus_valid_o;
  logic              bus_ready_i;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [STRB_W-1:0] bus_wstrb_o;
  logic              bus_rvalid_i;
  logic [DATA_W-1:0] bus_rdata_i;

  modport master (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wstrb_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
    input  bus_ready_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wstrb_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
    output bus_ready_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding memory bus arbiter between instruction fetch (IF) and load/store (LS).
// Define MEM_ARB_RR_EN for round-robin priority; otherwise LS always wins over IF.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic         clock,
  input logic         reset,
  mem_arbiter_if.master arb
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t            r_state;
  logic              r_ownerLs;
  logic              r_busValid;
  logic              r_busWe;
  logic [ADDR_W-1:0] r_busAddr;
  logic [DATA_W-1:0] r_busWdata;
  logic [STRB_W-1:0] r_busWstrb;
  logic              r_ifRvalid;
  logic [DATA_W-1:0] r_ifRdata;
  logic              r_lsRvalid;
  logic [DATA_W-1:0] r_lsRdata;

  logic w_idle;
  logic w_lsPriority;
  logic w_lsWins;
  logic w_grantIf;
  logic w_grantLs;

`ifdef MEM_ARB_RR_EN
  // Remembers which side was granted last; the other side wins the next tie.
  logic r_lastLs;
  assign w_lsPriority = ~r_lastLs;
`else
  assign w_lsPriority = 1'b1;
`endif

  // Grants are combinational so a requester sees acceptance in its request cycle.
  assign w_idle    = (r_state == IDLE) && !reset;
  assign w_lsWins  = arb.ls_req_i && (!arb.if_req_i || w_lsPriority);
  assign w_grantLs = w_idle && w_lsWins;
  assign w_grantIf = w_idle && arb.if_req_i && !w_lsWins;

  assign arb.if_gnt_o    = w_grantIf;
  assign arb.ls_gnt_o    = w_grantLs;
  assign arb.bus_valid_o = r_busValid;
  assign arb.bus_we_o    = r_busWe;
  assign arb.bus_addr_o  = r_busAddr;
  assign arb.bus_wdata_o = r_busWdata;
  assign arb.bus_wstrb_o = r_busWstrb;
  assign arb.if_rvalid_o = r_ifRvalid;
  assign arb.if_rdata_o  = r_ifRdata;
  assign arb.ls_rvalid_o = r_lsRvalid;
  assign arb.ls_rdata_o  = r_lsRdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ownerLs  <= 1'b0;
      r_busValid <= 1'b0;
      r_busWe    <= 1'b0;
      r_busAddr  <= '0;
      r_busWdata <= '0;
      r_busWstrb <= '0;
      r_ifRvalid <= 1'b0;
      r_ifRdata  <= '0;
      r_lsRvalid <= 1'b0;
      r_lsRdata  <= '0;
`ifdef MEM_ARB_RR_EN
      r_lastLs   <= 1'b0;
`endif
    end else begin
      r_ifRvalid <= 1'b0;
      r_lsRvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grantLs) begin
            r_state    <= REQ;
            r_ownerLs  <= 1'b1;
            r_busValid <= 1'b1;
            r_busWe    <= arb.ls_we_i;
            r_busAddr  <= arb.ls_addr_i;
            r_busWdata <= arb.ls_wdata_i;
            r_busWstrb <= arb.ls_wstrb_i;
`ifdef MEM_ARB_RR_EN
            r_lastLs   <= 1'b1;
`endif
          end else if (w_grantIf) begin
            r_state    <= REQ;
            r_ownerLs  <= 1'b0;
            r_busValid <= 1'b1;
            r_busWe    <= 1'b0;
            r_busAddr  <= arb.if_addr_i;
            r_busWdata <= '0;
            r_busWstrb <= '1;
`ifdef MEM_ARB_RR_EN
            r_lastLs   <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (arb.bus_ready_i) begin
            r_state    <= RESP;
            r_busValid <= 1'b0;
          end
        end
        RESP: begin
          // Write acks return zero data so LS never sees stale read data.
          if (arb.bus_rvalid_i) begin
            r_state <= IDLE;
            if (r_ownerLs) begin
              r_lsRvalid <= 1'b1;
              r_lsRdata  <= r_busWe ? '0 : arb.bus_rdata_i;
            end else begin
              r_ifRvalid <= 1'b1;
              r_ifRdata  <= arb.bus_rdata_i;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_busValid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level reference model predicts grants,
// bus requests and responses cycle by cycle; directed scenarios run first.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) mif ();

  mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock),
    .reset(reset),
    .arb  (mif)
  );

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: transaction phase 0 = free, 1 = request on bus, 2 = awaiting response.
  int          phase      = 0;
  bit          ownerLs    = 1'b0;
  bit          lastLs     = 1'b0;
  bit          txWe       = 1'b0;
  logic [63:0] txAddr     = '0;
  logic [63:0] txWdata    = '0;
  logic [7:0]  txWstrb    = '0;
  bit          expIfRv    = 1'b0;
  bit          expLsRv    = 1'b0;
  logic [63:0] expIfRdata = '0;
  logic [63:0] expLsRdata = '0;

  int          respWait   = 0;
  int          respMin    = 0;
  int          respMax    = 0;
  bit          rdataFixed = 1'b0;
  logic [63:0] rdataValue = '0;

  bit          ifPend  = 1'b0;
  bit          lsPend  = 1'b0;
  logic [63:0] ifAddr  = '0;
  logic [63:0] lsAddr  = '0;
  logic [63:0] lsWdata = '0;
  bit          lsWe    = 1'b0;
  logic [7:0]  lsWstrb = '0;

  bit sawIfGnt = 1'b0;
  bit sawLsGnt = 1'b0;
  bit grantLog[$];
  int validCycles = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic bit lsFirst();
`ifdef MEM_ARB_RR_EN
    return !lastLs;
`else
    return 1'b1;
`endif
  endfunction

  // Called just after a negedge with inputs already driven: check, advance model, wait a cycle.
  task automatic applyStimulus();
    bit lsWins;
    bit expIfGnt;
    bit expLsGnt;
    #1;
    lsWins   = mif.ls_req_i && (!mif.if_req_i || lsFirst());
    expLsGnt = !reset && (phase == 0) && lsWins;
    expIfGnt = !reset && (phase == 0) && mif.if_req_i && !lsWins;
    checkOutput("if_gnt", mif.if_gnt_o, expIfGnt);
    checkOutput("ls_gnt", mif.ls_gnt_o, expLsGnt);
    checkOutput("bus_valid", mif.bus_valid_o, phase == 1);
    if (phase == 1) begin
      checkOutput("bus_we", mif.bus_we_o, txWe);
      checkOutput("bus_addr", mif.bus_addr_o, txAddr);
      checkOutput("bus_wstrb", mif.bus_wstrb_o, txWstrb);
      if (txWe) checkOutput("bus_wdata", mif.bus_wdata_o, txWdata);
    end
    checkOutput("if_rvalid", mif.if_rvalid_o, expIfRv);
    checkOutput("ls_rvalid", mif.ls_rvalid_o, expLsRv);
    checkOutput("if_rdata", mif.if_rdata_o, expIfRdata);
    checkOutput("ls_rdata", mif.ls_rdata_o, expLsRdata);

    sawIfGnt = mif.if_gnt_o;
    sawLsGnt = mif.ls_gnt_o;
    if (sawLsGnt) grantLog.push_back(1'b1);
    if (sawIfGnt) grantLog.push_back(1'b0);
    if (mif.bus_valid_o) validCycles++;

    expIfRv = 1'b0;
    expLsRv = 1'b0;
    if (reset) begin
      phase      = 0;
      lastLs     = 1'b0;
      ownerLs    = 1'b0;
      expIfRdata = '0;
      expLsRdata = '0;
    end else begin
      case (phase)
        0: if (expLsGnt || expIfGnt) begin
          phase   = 1;
          ownerLs = expLsGnt;
          lastLs  = expLsGnt;
          txWe    = expLsGnt && mif.ls_we_i;
          txAddr  = expLsGnt ? mif.ls_addr_i : mif.if_addr_i;
          txWdata = mif.ls_wdata_i;
          txWstrb = expLsGnt ? mif.ls_wstrb_i : 8'hFF;
        end
        1: if (mif.bus_ready_i) begin
          phase    = 2;
          respWait = int'($urandom_range(respMax, respMin));
        end
        default: if (mif.bus_rvalid_i) begin
          phase = 0;
          if (ownerLs) begin
            expLsRv    = 1'b1;
            expLsRdata = txWe ? 64'h0 : mif.bus_rdata_i;
          end else begin
            expIfRv    = 1'b1;
            expIfRdata = mif.bus_rdata_i;
          end
        end
      endcase
    end
    @(negedge clock);
  endtask

  // One cycle of requesters holding/issuing requests and a bus responder with random timing.
  task automatic autoCycle(input int ifPct, input int lsPct, input int readyPct,
                           input int spurPct, input int dropPct);
    if (!ifPend && $urandom_range(99, 0) < ifPct) begin
      ifPend = 1'b1;
      ifAddr = {$urandom, $urandom};
    end else if (ifPend && $urandom_range(99, 0) < dropPct) begin
      ifPend = 1'b0;
    end
    if (!lsPend && $urandom_range(99, 0) < lsPct) begin
      lsPend  = 1'b1;
      lsWe    = 1'($urandom_range(1, 0));
      lsAddr  = {$urandom, $urandom};
      lsWdata = {$urandom, $urandom};
      lsWstrb = 8'($urandom);
    end else if (lsPend && $urandom_range(99, 0) < dropPct) begin
      lsPend = 1'b0;
    end
    mif.if_req_i    = ifPend;
    mif.if_addr_i   = ifAddr;
    mif.ls_req_i    = lsPend;
    mif.ls_we_i     = lsWe;
    mif.ls_addr_i   = lsAddr;
    mif.ls_wdata_i  = lsWdata;
    mif.ls_wstrb_i  = lsWstrb;
    mif.bus_ready_i = ($urandom_range(99, 0) < readyPct);
    mif.bus_rdata_i = rdataFixed ? rdataValue : {$urandom, $urandom};
    if (phase == 2) begin
      mif.bus_rvalid_i = (respWait == 0);
      if (respWait > 0) respWait--;
    end else begin
      mif.bus_rvalid_i = ($urandom_range(99, 0) < spurPct);
    end
    applyStimulus();
    if (sawIfGnt) ifPend = 1'b0;
    if (sawLsGnt) lsPend = 1'b0;
  endtask

  task automatic runCycles(input int n, input int ifPct, input int lsPct, input int readyPct,
                           input int spurPct, input int dropPct);
    for (int i = 0; i < n; i++) autoCycle(ifPct, lsPct, readyPct, spurPct, dropPct);
  endtask

  task automatic idleInputs();
    mif.if_req_i     = 1'b0;
    mif.if_addr_i    = '0;
    mif.ls_req_i     = 1'b0;
    mif.ls_we_i      = 1'b0;
    mif.ls_addr_i    = '0;
    mif.ls_wdata_i   = '0;
    mif.ls_wstrb_i   = '0;
    mif.bus_ready_i  = 1'b0;
    mif.bus_rvalid_i = 1'b0;
    mif.bus_rdata_i  = '0;
  endtask

  task automatic doReset();
    reset  = 1'b1;
    ifPend = 1'b0;
    lsPend = 1'b0;
    idleInputs();
    applyStimulus();
    reset = 1'b0;
  endtask

  initial begin
    bit foundIf;
    idleInputs();
    @(negedge clock);
    doReset();
    checkOutput("reset bus_valid", mif.bus_valid_o, 64'h0);
    checkOutput("reset bus_addr", mif.bus_addr_o, 64'h0);
    checkOutput("reset bus_wdata", mif.bus_wdata_o, 64'h0);
    checkOutput("reset bus_wstrb", mif.bus_wstrb_o, 64'h0);
    checkOutput("reset bus_we", mif.bus_we_o, 64'h0);
    checkOutput("reset if_rdata", mif.if_rdata_o, 64'h0);
    checkOutput("reset ls_rdata", mif.ls_rdata_o, 64'h0);

    // IF read: ready one cycle after grant, response three cycles into RESP
    rdataFixed = 1'b1;
    rdataValue = 64'h00000013_00000093;
    respMin = 2; respMax = 2;
    ifPend = 1'b1; ifAddr = 64'h80000000;
    runCycles(1, 0, 0, 0, 0, 0);
    runCycles(7, 0, 0, 100, 0, 0);
    checkOutput("t1 if_rdata", mif.if_rdata_o, 64'h00000013_00000093);

    // LS write with partial strobes
    respMin = 0; respMax = 0;
    lsPend = 1'b1; lsWe = 1'b1; lsAddr = 64'h80001000;
    lsWdata = 64'hDEADBEEF_CAFEF00D; lsWstrb = 8'h0F;
    grantLog.delete();
    runCycles(6, 0, 0, 100, 0, 0);
    checkOutput("t2 ls granted", grantLog.size(), 64'd1);
    checkOutput("t2 ls_rdata", mif.ls_rdata_o, 64'h0);
    checkOutput("t2 if_rdata kept", mif.if_rdata_o, 64'h00000013_00000093);

    // Spurious response while idle must have no effect
    idleInputs();
    mif.bus_rvalid_i = 1'b1;
    mif.bus_rdata_i  = 64'hFFFF;
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkOutput("spur if_rdata", mif.if_rdata_o, 64'h00000013_00000093);
    checkOutput("spur ls_rdata", mif.ls_rdata_o, 64'h0);
    rdataFixed = 1'b0;

    // Contention with continuous LS traffic
    doReset();
    ifPend = 1'b1; ifAddr = 64'h1000;
    lsPend = 1'b1; lsWe = 1'b0; lsAddr = 64'h2000; lsWdata = '0; lsWstrb = 8'hFF;
    grantLog.delete();
    runCycles(5, 0, 100, 100, 0, 0);
    checkOutput("cont grant count", (grantLog.size() >= 2), 64'd1);
    if (grantLog.size() >= 2) begin
      checkOutput("cont first winner LS", grantLog[0], 64'd1);
`ifdef MEM_ARB_RR_EN
      checkOutput("cont second winner IF", grantLog[1], 64'd0);
`else
      checkOutput("cont second winner LS", grantLog[1], 64'd1);
`endif
    end
    runCycles(12, 0, 0, 100, 0, 0);
    foundIf = 1'b0;
    foreach (grantLog[k]) if (!grantLog[k]) foundIf = 1'b1;
    checkOutput("cont IF served", foundIf, 64'd1);

    // Ready back-pressure with the other side waiting
    doReset();
    lsPend = 1'b1; lsWe = 1'b1; lsAddr = 64'h3000; lsWdata = 64'h1122334455667788; lsWstrb = 8'hA5;
    ifPend = 1'b1; ifAddr = 64'h4000;
    grantLog.delete();
    validCycles = 0;
    runCycles(6, 0, 0, 0, 0, 0);
    runCycles(1, 0, 0, 100, 0, 0);
    checkOutput("bp valid cycles", validCycles, 64'd6);
    checkOutput("bp single grant", grantLog.size(), 64'd1);
    runCycles(12, 0, 0, 100, 0, 0);

    // Reset while waiting for a response
    respMin = 5; respMax = 5;
    ifPend = 1'b1; ifAddr = 64'h5000;
    runCycles(3, 0, 0, 100, 0, 0);
    checkOutput("rst in RESP", phase, 64'd2);
    doReset();
    idleInputs();
    mif.bus_rvalid_i = 1'b1;
    mif.bus_rdata_i  = 64'h1234;
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkOutput("rst bus_valid", mif.bus_valid_o, 64'h0);
    checkOutput("rst bus_addr", mif.bus_addr_o, 64'h0);
    checkOutput("rst if_rdata", mif.if_rdata_o, 64'h0);
    checkOutput("rst if_rvalid", mif.if_rvalid_o, 64'h0);
    respMin = 0; respMax = 0;
    ifPend = 1'b1; ifAddr = 64'h6000;
    grantLog.delete();
    runCycles(6, 0, 0, 100, 0, 0);
    checkOutput("rst fresh grant", grantLog.size(), 64'd1);
    if (grantLog.size() == 1) checkOutput("rst fresh IF", grantLog[0], 64'd0);

    // Randomized traffic
    respMin = 0; respMax = 3;
    runCycles(3000, 30, 30, 60, 10, 5);
    runCycles(30, 0, 0, 100, 0, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
